reg_row_seg: RTL and testbench

//  Parametrised compute row for the in-register ALU array: one N-bit register with up/dn read/write bus chaining.

---
 rtl/reg_row_seg_if.sv | 45 ++++
 rtl/reg_row_seg.sv | 154 +++++++++++++++
 tb/tb_reg_row_seg.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/reg_row_seg_if.sv
// Bus bundle for one compute row: neighbour read/write chains, request controls and status.
`timescale 1ns/1ps
interface reg_row_seg_if #(
    parameter int unsigned N = 32
);
    logic [N-1:0] rd_in_up;
    logic [N-1:0] rd_in_dn;
    logic [N-1:0] wr_in_up;
    logic [N-1:0] wr_in_dn;
    logic         rd_sel_up;
    logic         rd_sel_dn;
    logic         wr_sel_up;
    logic         wr_sel_dn;
    logic         wr_en;
    logic [3:0]   op_fa;
    logic         first_carry;
    logic         signed_mode;
    logic         sat_en;
    logic [N-1:0] rd_out_up;
    logic [N-1:0] rd_out_dn;
    logic [N-1:0] wr_out_up;
    logic [N-1:0] wr_out_dn;
    logic         busy;
    logic         done;
    logic         overflow;
    logic         signed_ovf;
    logic         op_err;
    logic [N-1:0] debug_row_reg;

    modport master (
        output rd_in_up, rd_in_dn, wr_in_up, wr_in_dn,
        output rd_sel_up, rd_sel_dn, wr_sel_up, wr_sel_dn,
        output wr_en, op_fa, first_carry, signed_mode, sat_en,
        input  rd_out_up, rd_out_dn, wr_out_up, wr_out_dn,
        input  busy, done, overflow, signed_ovf, op_err, debug_row_reg
    );

    modport slave (
        input  rd_in_up, rd_in_dn, wr_in_up, wr_in_dn,
        input  rd_sel_up, rd_sel_dn, wr_sel_up, wr_sel_dn,
        input  wr_en, op_fa, first_carry, signed_mode, sat_en,
        output rd_out_up, rd_out_dn, wr_out_up, wr_out_dn,
        output busy, done, overflow, signed_ovf, op_err, debug_row_reg
    );
endinterface

// File: rtl/reg_row_seg.sv
// One row of the in-register ALU array: N-bit register updated in place by LOAD/AND/XOR/OR
// (single cycle) or a segmented SUM that adds one W-bit slice per clock.
`timescale 1ns/1ps
module reg_row_seg #(
    parameter int unsigned N   = 32,
    parameter int unsigned SEG = 4
) (
    input logic         clk,
    input logic         rst,
    reg_row_seg_if.slave bus
);
    localparam int unsigned W    = N / SEG;
    localparam int unsigned CntW = (SEG > 1) ? $clog2(SEG) : 1;

    generate
        if (N % SEG != 0) begin : g_bad_seg
            $error("reg_row_seg: N must be a multiple of SEG");
        end
    endgenerate

    typedef enum logic [0:0] {StIdle, StSum} state_e;

    state_e          state_q, state_d;
    logic [N-1:0]    r_q, r_d;
    logic [N-1:0]    b_q, b_d;
    logic [CntW-1:0] seg_q, seg_d;
    logic            carry_q, carry_d;
    logic            sat_q, sat_d;
    logic            smode_q, smode_d;
    logic            ovf_q, ovf_d;
    logic            sovf_q, sovf_d;
    logic            done_q, done_d;
    logic            err_q, err_d;

    logic            idle, accept, illegal, last;
    logic [N-1:0]    b_in, opb, r_sum;
    logic            cin, sat_eff, smode_eff;
    logic [CntW-1:0] idx;
    logic [W-1:0]    sl_a, sl_b, sl_s;
    logic            sl_c, top_cin, sl_sovf;

    // Slice datapath: at accept it works on live inputs, afterwards on the latched operand.
    always_comb begin
        idle      = (state_q == StIdle);
        b_in      = bus.wr_sel_up ? bus.wr_in_up : bus.wr_in_dn;
        opb       = idle ? b_in : b_q;
        cin       = idle ? bus.first_carry : carry_q;
        sat_eff   = idle ? bus.sat_en : sat_q;
        smode_eff = idle ? bus.signed_mode : smode_q;
        idx       = idle ? '0 : seg_q;
        sl_a      = r_q[idx*W +: W];
        sl_b      = opb[idx*W +: W];
        {sl_c, sl_s} = {1'b0, sl_a} + {1'b0, sl_b} + {{W{1'b0}}, cin};
        top_cin   = sl_a[W-1] ^ sl_b[W-1] ^ sl_s[W-1];
        sl_sovf   = sl_c ^ top_cin;
        last      = (idx == CntW'(SEG - 1));
        r_sum     = r_q;
        r_sum[idx*W +: W] = sl_s;
        illegal   = !$onehot0(bus.op_fa);
        accept    = bus.wr_en && idle && (bus.wr_sel_up || bus.wr_sel_dn);
    end

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        b_d     = b_q;
        seg_d   = seg_q;
        carry_d = carry_q;
        sat_d   = sat_q;
        smode_d = smode_q;
        ovf_d   = ovf_q;
        sovf_d  = sovf_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        // SUM is "active" on the accept edge or on any edge while in StSum.
        if ((idle && accept && !illegal && bus.op_fa == 4'b0001) || !idle) begin
            r_d = r_sum;
            if (idle) begin
                b_d     = b_in;
                sat_d   = bus.sat_en;
                smode_d = bus.signed_mode;
                ovf_d   = 1'b0;
                sovf_d  = 1'b0;
            end
            if (last) begin
                ovf_d   = sl_c;
                sovf_d  = sl_sovf;
                done_d  = 1'b1;
                seg_d   = '0;
                state_d = StIdle;
                if (sat_eff && !smode_eff && sl_c) begin
                    r_d = '1;
                end else if (sat_eff && smode_eff && sl_sovf) begin
                    r_d = opb[N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
                end
            end else begin
                carry_d = sl_c;
                seg_d   = idx + 1'b1;
                state_d = StSum;
            end
        end else if (accept) begin
            if (illegal) begin
                err_d = 1'b1;
            end else begin
                done_d = 1'b1;
                unique case (bus.op_fa)
                    4'b0010: r_d = r_q & b_in;
                    4'b0100: r_d = r_q ^ b_in;
                    4'b1000: r_d = r_q | b_in;
                    default: r_d = b_in;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            r_q     <= '0;
            b_q     <= '0;
            seg_q   <= '0;
            carry_q <= 1'b0;
            sat_q   <= 1'b0;
            smode_q <= 1'b0;
            ovf_q   <= 1'b0;
            sovf_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            b_q     <= b_d;
            seg_q   <= seg_d;
            carry_q <= carry_d;
            sat_q   <= sat_d;
            smode_q <= smode_d;
            ovf_q   <= ovf_d;
            sovf_q  <= sovf_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign bus.rd_out_up     = bus.rd_sel_up ? r_q : bus.rd_in_up;
    assign bus.rd_out_dn     = bus.rd_sel_dn ? r_q : bus.rd_in_dn;
    assign bus.wr_out_up     = bus.wr_in_up;
    assign bus.wr_out_dn     = bus.wr_in_dn;
    assign bus.busy          = (state_q == StSum);
    assign bus.done          = done_q;
    assign bus.overflow      = ovf_q;
    assign bus.signed_ovf    = sovf_q;
    assign bus.op_err        = err_q;
    assign bus.debug_row_reg = r_q;
endmodule

// File: tb/tb_reg_row_seg.sv
// Directed bench for reg_row_seg (N=32, SEG=4): vector table plus hand-written multi-cycle sequences.
`timescale 1ns/1ps
module tb_reg_row_seg;
    localparam int unsigned N = 32;
    localparam logic [3:0] OpSum = 4'b0001, OpAnd = 4'b0010, OpXor = 4'b0100;
    localparam logic [3:0] OpOr  = 4'b1000, OpLoad = 4'b0000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    reg_row_seg_if #(.N(N)) bus ();
    reg_row_seg #(.N(N), .SEG(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int errors = 0;
    logic model_ovf = 1'b0;
    logic model_sovf = 1'b0;

    typedef struct {
        logic [31:0] init;
        logic [3:0]  op;
        logic [31:0] b;
        logic        cin;
        logic        smode;
        logic        sat;
        logic [31:0] exp_r;
        logic        exp_ovf;
        logic        exp_sovf;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive_req(input logic [3:0] op, input logic [31:0] data, input logic cin,
                             input logic smode, input logic sat, input logic use_up);
        bus.op_fa       = op;
        bus.first_carry = cin;
        bus.signed_mode = smode;
        bus.sat_en      = sat;
        bus.wr_sel_up   = use_up;
        bus.wr_sel_dn   = 1'b1;
        bus.wr_in_up    = use_up ? data : ~data;
        bus.wr_in_dn    = use_up ? ~data : data;
        bus.wr_en       = 1'b1;
    endtask

    // Called at the negedge after the accept edge; returns at the negedge where done is seen.
    task automatic wait_done(output int busy_cnt, output bit got_done);
        busy_cnt = 0;
        got_done = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (bus.done) begin
                got_done = 1'b1;
                break;
            end
            if (bus.busy) busy_cnt++;
            @(negedge clk);
        end
    endtask

    task automatic run_op(input logic [3:0] op, input logic [31:0] data, input logic cin,
                          input logic smode, input logic sat, input logic use_up,
                          output int busy_cnt, output bit got_done);
        @(negedge clk);
        drive_req(op, data, cin, smode, sat, use_up);
        @(negedge clk);
        bus.wr_en       = 1'b0;
        bus.wr_in_up    = 32'h5A5A_C3C3;
        bus.wr_in_dn    = 32'hA5A5_3C3C;
        bus.first_carry = ~cin;
        wait_done(busy_cnt, got_done);
    endtask

    initial begin
        int  bc;
        bit  gd;
        string nm;

        vecs[0]  = '{32'h0000_00FF, OpSum,  32'h0000_0001, 0, 0, 0, 32'h0000_0100, 0, 0};
        vecs[1]  = '{32'hFFFF_FFFF, OpSum,  32'h0000_0001, 0, 0, 0, 32'h0000_0000, 1, 0};
        vecs[2]  = '{32'hFFFF_FFFF, OpSum,  32'h0000_0001, 0, 0, 1, 32'hFFFF_FFFF, 1, 0};
        vecs[3]  = '{32'h7FFF_FFFF, OpSum,  32'h0000_0001, 0, 1, 0, 32'h8000_0000, 0, 1};
        vecs[4]  = '{32'h7FFF_FFFF, OpSum,  32'h0000_0001, 0, 1, 1, 32'h7FFF_FFFF, 0, 1};
        vecs[5]  = '{32'h1234_5678, OpAnd,  32'h0F0F_0F0F, 0, 0, 0, 32'h0204_0608, 0, 0};
        vecs[6]  = '{32'h1234_5678, OpXor,  32'hFFFF_0000, 0, 0, 0, 32'hEDCB_5678, 0, 0};
        vecs[7]  = '{32'h1234_5678, OpOr,   32'h0000_FFFF, 0, 0, 0, 32'h1234_FFFF, 0, 0};
        vecs[8]  = '{32'h0000_0000, OpLoad, 32'hCAFE_BABE, 0, 0, 0, 32'hCAFE_BABE, 0, 0};
        vecs[9]  = '{32'h0000_FFFF, OpSum,  32'h0000_FFFF, 1, 0, 0, 32'h0001_FFFF, 0, 0};
        vecs[10] = '{32'h8000_0000, OpSum,  32'h8000_0000, 0, 1, 1, 32'h8000_0000, 1, 1};
        vecs[11] = '{32'h8000_0000, OpSum,  32'h8000_0000, 0, 0, 1, 32'hFFFF_FFFF, 1, 1};

        rst = 1'b1;
        bus.rd_in_up = 32'h1357_9BDF;
        bus.rd_in_dn = 32'h2468_ACE0;
        bus.wr_in_up = '0;
        bus.wr_in_dn = '0;
        bus.rd_sel_up = 1'b0;
        bus.rd_sel_dn = 1'b0;
        bus.wr_sel_up = 1'b0;
        bus.wr_sel_dn = 1'b0;
        bus.wr_en = 1'b0;
        bus.op_fa = OpLoad;
        bus.first_carry = 1'b0;
        bus.signed_mode = 1'b0;
        bus.sat_en = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_r", bus.debug_row_reg, 32'h0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_ovf", bus.overflow, 0);
        check("rst_sovf", bus.signed_ovf, 0);
        check("rst_op_err", bus.op_err, 0);
        check("rst_rd_out_up", bus.rd_out_up, 32'h1357_9BDF);
        bus.wr_in_dn = 32'h0BAD_F00D;
        #1 check("wr_out_dn_pass", bus.wr_out_dn, 32'h0BAD_F00D);
        rst = 1'b0;

        // Table-driven vectors: LOAD the initial value through dn, then apply the op through up
        for (int i = 0; i < 12; i++) begin
            run_op(OpLoad, vecs[i].init, 0, 0, 0, 0, bc, gd);
            $sformat(nm, "v%0d_init", i);
            check(nm, bus.debug_row_reg, vecs[i].init);
            run_op(vecs[i].op, vecs[i].b, vecs[i].cin, vecs[i].smode, vecs[i].sat, 1, bc, gd);
            if (vecs[i].op == OpSum) begin
                model_ovf  = vecs[i].exp_ovf;
                model_sovf = vecs[i].exp_sovf;
            end
            $sformat(nm, "v%0d_done", i);
            check(nm, gd, 1);
            $sformat(nm, "v%0d_busy_cycles", i);
            check(nm, bc, (vecs[i].op == OpSum) ? 3 : 0);
            $sformat(nm, "v%0d_r", i);
            check(nm, bus.debug_row_reg, vecs[i].exp_r);
            $sformat(nm, "v%0d_ovf", i);
            check(nm, bus.overflow, model_ovf);
            $sformat(nm, "v%0d_sovf", i);
            check(nm, bus.signed_ovf, model_sovf);
        end

        // Requests while busy are ignored
        run_op(OpLoad, 32'h0000_00FF, 0, 0, 0, 0, bc, gd);
        @(negedge clk);
        drive_req(OpSum, 32'h0000_0001, 0, 0, 0, 1);
        @(negedge clk);
        drive_req(OpLoad, 32'hDEAD_BEEF, 0, 0, 0, 1);
        wait_done(bc, gd);
        bus.wr_en = 1'b0;
        check("busy_ign_done", gd, 1);
        check("busy_ign_cycles", bc, 3);
        check("busy_ign_r", bus.debug_row_reg, 32'h0000_0100);
        check("busy_ign_ovf", bus.overflow, 0);

        // Illegal op: error pulse only
        @(negedge clk);
        drive_req(4'b0011, 32'hFFFF_FFFF, 0, 0, 0, 1);
        @(negedge clk);
        bus.wr_en = 1'b0;
        check("op_err_pulse", bus.op_err, 1);
        check("op_err_no_done", bus.done, 0);
        check("op_err_r", bus.debug_row_reg, 32'h0000_0100);
        @(negedge clk);
        check("op_err_clear", bus.op_err, 0);
        check("op_err_no_done2", bus.done, 0);

        // wr_en with neither select is ignored
        drive_req(OpLoad, 32'h1111_1111, 0, 0, 0, 0);
        bus.wr_sel_dn = 1'b0;
        @(negedge clk);
        bus.wr_en = 1'b0;
        check("nosel_done", bus.done, 0);
        check("nosel_r", bus.debug_row_reg, 32'h0000_0100);

        // Back-to-back: new request accepted in the done cycle
        run_op(OpLoad, 32'h0000_0010, 0, 0, 0, 1, bc, gd);
        drive_req(OpXor, 32'h0000_00FF, 0, 0, 0, 1);
        @(negedge clk);
        bus.wr_en = 1'b0;
        check("b2b_done", bus.done, 1);
        check("b2b_r", bus.debug_row_reg, 32'h0000_00EF);

        // Mid-SUM reads, then reset where slice 2 would be written
        run_op(OpLoad, 32'hFFFF_FFFF, 0, 0, 0, 1, bc, gd);
        @(negedge clk);
        drive_req(OpSum, 32'h0000_0001, 0, 0, 0, 1);
        @(negedge clk);
        bus.wr_en = 1'b0;
        bus.rd_sel_dn = 1'b1;
        check("mid_r_slice0", bus.debug_row_reg, 32'hFFFF_FF00);
        check("mid_busy", bus.busy, 1);
        check("mid_rd_out_dn", bus.rd_out_dn, 32'hFFFF_FF00);
        @(negedge clk);
        check("mid_r_slice1", bus.debug_row_reg, 32'hFFFF_0000);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.rd_sel_dn = 1'b0;
        check("abort_r", bus.debug_row_reg, 32'h0);
        check("abort_busy", bus.busy, 0);
        check("abort_done", bus.done, 0);
        check("abort_ovf", bus.overflow, 0);
        @(negedge clk);
        check("abort_no_done", bus.done, 0);
        run_op(OpXor, 32'h0F0F_0F0F, 0, 0, 0, 1, bc, gd);
        check("post_rst_xor_done", gd, 1);
        check("post_rst_xor_r", bus.debug_row_reg, 32'h0F0F_0F0F);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
